// File: rtl/alu_pkg.sv
// alu_pkg -- constants and types shared by the ALU write-back path.
//
// Contents:
//   DATA_W / RD_W / SEL_W : result, destination-index and select widths
//   alu_sel_e             : the sixteen 4-bit ALU select codes
//   wb_entry_t            : one result-queue entry
//   is_zero()             : zero-flag helper
//
// Macro ALU_WB_FLAGS_EN: when defined, each queue entry also carries the
// zero/negative flags computed from the result when it is pushed.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int RD_W   = 4;
  localparam int SEL_W  = 4;

  typedef enum logic [SEL_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOT  = 4'd5,
    ALU_SHL  = 4'd6,
    ALU_SHR  = 4'd7,
    ALU_SAR  = 4'd8,
    ALU_ROL  = 4'd9,
    ALU_ROR  = 4'd10,
    ALU_INC  = 4'd11,
    ALU_DEC  = 4'd12,
    ALU_PASA = 4'd13,
    ALU_PASB = 4'd14,
    ALU_CMP  = 4'd15
  } alu_sel_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    alu_sel_e          sel;
    logic [RD_W-1:0]   rd;
    logic              wb_en;
`ifdef ALU_WB_FLAGS_EN
    logic              z;
    logic              n;
`endif
  } wb_entry_t;

  function automatic logic is_zero(input logic [DATA_W-1:0] v);
    return (v == '0);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo -- small circular queue holding write-back entries.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   flush          : clear the queue at the next edge, dropping push/pop
//   push / wdata   : write one entry (ignored when full)
//   pop            : retire the head entry (ignored when empty)
//   rdata          : head entry, readable as soon as it is written
//   full / empty   : occupancy status
//
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             do_push, do_pop;

  assign full  = (occ_q == FULL_OCC);
  assign empty = (occ_q == '0);

  // Flush wins over everything happening in the same cycle.
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage is cleared on reset so the head outputs read as zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];

endmodule

// File: rtl/alu_wb_stage.sv
// alu_wb_stage -- queues ALU results and hands them to the register file.
//
// Ports:
//   clk, rst_n                          : clock, asynchronous active-low reset
//   in_valid/in_ready                   : upstream handshake
//   in_res, in_sel, in_rd, in_wb_en     : result, select code, dest, write enable
//   flush                               : synchronous queue clear
//   out_valid/out_ready                 : register-file handshake
//   out_data, out_rd, out_sel           : head entry fields
//   out_we                              : head is valid and wants writing back
//   out_z, out_n                        : head zero / sign flags
//   wr_count                            : saturating count of retired writes
//
// Macro ALU_WB_FLAGS_EN: store per-entry flags; otherwise out_z/out_n are 0.
module alu_wb_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_res,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_wb_en,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_we,
  output logic              out_z,
  output logic              out_n,
  output logic [SEL_W-1:0]  out_sel,
  output logic [CNT_W-1:0]  wr_count
);

  wb_entry_t        in_entry, head;
  logic             full, empty;
  logic             push, pop;
  logic [CNT_W-1:0] wr_count_q, wr_count_d;

  always_comb begin
    in_entry       = '0;
    in_entry.data  = in_res;
    in_entry.sel   = alu_sel_e'(in_sel);
    in_entry.rd    = in_rd;
    in_entry.wb_en = in_wb_en;
`ifdef ALU_WB_FLAGS_EN
    in_entry.z     = is_zero(in_res);
    in_entry.n     = in_res[DATA_W-1];
`endif
  end

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(wb_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (in_entry),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign out_data = head.data;
  assign out_rd   = head.rd;
  assign out_sel  = head.sel;
  assign out_we   = out_valid & head.wb_en;
`ifdef ALU_WB_FLAGS_EN
  assign out_z    = head.z;
  assign out_n    = head.n;
`else
  assign out_z    = 1'b0;
  assign out_n    = 1'b0;
`endif

  // A pop squashed by flush never retires, so it is not counted.
  always_comb begin
    wr_count_d = wr_count_q;
    if (pop && head.wb_en && !flush && (wr_count_q != '1))
      wr_count_d = wr_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_count_q <= '0;
    else        wr_count_q <= wr_count_d;
  end

  assign wr_count = wr_count_q;

endmodule

// File: doc/alu_wb_stage.md
ALU_WB_STAGE -- requirements
Module: alu_wb_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 2, result-queue entries (power of two, 2..8).
REQ-002 SHALL have parameter CNT_W, default 16, width of the retired-write counter.
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  in  1  upstream ALU result valid.
REQ-006 SHALL have port in_ready  out  1  queue can accept this cycle.
REQ-007 SHALL have port in_res  in  8  ALU result byte.
REQ-008 SHALL have port in_sel  in  4  ALU select code that produced in_res.
REQ-009 SHALL have port in_rd  in  4  destination register index.
REQ-010 SHALL have port in_wb_en  in  1  1 = write result back, 0 = discard after retire.
REQ-011 SHALL have port flush  in  1  synchronous queue clear.
REQ-012 SHALL have port out_valid  out  1  head entry valid.
REQ-013 SHALL have port out_ready  in  1  register file consumes head.
REQ-014 SHALL have port out_data  out  8  head result.
REQ-015 SHALL have port out_rd  out  4  head destination index.
REQ-016 SHALL have port out_we  out  1  out_valid AND head wb_en.
REQ-017 SHALL have port out_z  out  1  head result zero flag.
REQ-018 SHALL have port out_n  out  1  head result bit 7.
REQ-019 SHALL have port out_sel  out  4  head select code.
REQ-020 SHALL have port wr_count  out  CNT_W  retired writes with wb_en=1.

Function
REQ-021 SHALL push when in_valid AND in_ready; pop when out_valid AND out_ready.
REQ-022 SHALL drive in_ready = (occupancy < DEPTH), independent of out_ready (no full-queue pass-through).
REQ-023 SHALL present a pushed entry on out_* no earlier than the cycle after the push (latency 1, no bypass).
REQ-024 SHALL keep out_* stable while out_valid=1 and out_ready=0.
REQ-025 SHALL allow simultaneous push and pop when occupancy is 1..DEPTH-1, occupancy unchanged.
REQ-026 SHALL ignore out_ready when empty and in_valid when full; pointers wrap modulo DEPTH.
REQ-027 SHALL compute out_z = (stored result == 8'h00) and out_n = stored result[7] at push time.
REQ-028 SHALL increment wr_count on each pop with wb_en=1, saturating at all-ones.
REQ-029 SHALL, on flush=1, empty the queue next edge, dropping any same-cycle push/pop; wr_count unaffected.

Reset
REQ-030 SHALL on rst_n=0 clear occupancy and pointers, forcing out_valid=0, out_we=0, in_ready=1.
REQ-031 SHALL reset out_data, out_rd, out_sel, out_z, out_n and wr_count to 0.
REQ-032 SHALL discard queued entries when reset asserts mid-operation; first push after release is handled normally.

Configuration
REQ-033 SHALL honour macro ALU_WB_FLAGS_EN: defined -> flag bits stored per entry per REQ-027.
REQ-034 SHALL, without ALU_WB_FLAGS_EN, store no flag bits and tie out_z=0, out_n=0.

Structure
REQ-035 SHALL take ALU select encodings (4-bit codes 0..15) and the DATA_W=8, RD_W=4 constants from shared package alu_pkg.
REQ-036 SHALL implement storage in one sub-module wb_fifo (parameterised DEPTH, entry width); counter and flag logic stay in the top.

Verification
REQ-037 SHALL test reset: rst_n low mid-stream with 2 entries -> out_valid=0, in_ready=1, wr_count=0 same cycle.
REQ-038 SHALL test fill: push 8'h00, 8'h80 with out_ready=0 -> in_ready=0 after 2nd push; head out_z=1,out_n=0; then out_z=0,out_n=1.
REQ-039 SHALL test backpressure: out_ready=0 for 5 cycles -> out_data/out_rd/out_sel unchanged every cycle.
REQ-040 SHALL test concurrent push/pop at occupancy 1 with stream 1..20 -> outputs 1..20 in order, one per cycle, occupancy stays 1.
REQ-041 SHALL test flush with in_valid=1 at full -> queue empty next cycle, pushed value never appears on out_data.
REQ-042 SHALL test counter: CNT_W=4, 17 pops with wb_en=1 plus 3 with wb_en=0 -> wr_count=4'hF, out_we=0 on the 3 discards.
